// File: rtl/tlb_entry_array_if.sv
// tlb_entry_array_if: lookup, refill and sfence signals of the TLB entry store
//   master: lookup requester / page-table walker / sfence source
//   slave : tlb_entry_array
interface tlb_entry_array_if #(
    parameter int VPN_W = 27,
    parameter int PPN_W = 20
);
    logic             req_valid;
    logic [VPN_W-1:0] req_vpn;
    logic             resp_valid;
    logic             resp_hit;
    logic [PPN_W-1:0] resp_ppn;
    logic [15:0]      resp_flags;
    logic             refill_valid;
    logic             refill_ready;
    logic [VPN_W-1:0] refill_vpn;
    logic [PPN_W-1:0] refill_ppn;
    logic [15:0]      refill_flags;
    logic             sfence_valid;
    logic             sfence_all;
    logic [VPN_W-1:0] sfence_vpn;
    modport master (
        output req_valid, req_vpn, refill_valid, refill_vpn, refill_ppn, refill_flags,
               sfence_valid, sfence_all, sfence_vpn,
        input  resp_valid, resp_hit, resp_ppn, resp_flags, refill_ready
    );
    modport slave (
        input  req_valid, req_vpn, refill_valid, refill_vpn, refill_ppn, refill_flags,
               sfence_valid, sfence_all, sfence_vpn,
        output resp_valid, resp_hit, resp_ppn, resp_flags, refill_ready
    );
endinterface

// File: rtl/tlb_entry_array.sv
// tlb_entry_array: fully-associative TLB store with registered lookup, sfence and round-robin refill
//   clk, rstnn : clock, asynchronous active-low reset
//   bus        : lookup request/response, walker refill handshake, sfence invalidate
module tlb_entry_array #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 27,
    parameter int PPN_W   = 20
) (
    input logic              clk,
    input logic              rstnn,
    tlb_entry_array_if.slave bus
);
    localparam int IW = $clog2(ENTRIES);
    logic [ENTRIES-1:0] valid;
    logic [VPN_W-1:0]   vpn_q   [ENTRIES];
    logic [PPN_W-1:0]   ppn_q   [ENTRIES];
    logic [15:0]        flags_q [ENTRIES];
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      rf_idx;
    logic [IW-1:0]      free_idx;
    logic [IW-1:0]      victim;
    logic [ENTRIES-1:0] sf_match;
    logic               hit_any;
    logic [PPN_W-1:0]   hit_ppn;
    logic [15:0]        hit_flags;
    logic               rf_match;
    logic               free_any;
    logic               accept;
    logic               resp_valid_q;
    logic               resp_hit_q;
    logic [PPN_W-1:0]   resp_ppn_q;
    logic [15:0]        resp_flags_q;
    // Descending scan so the lowest-index free entry wins.
    always_comb begin
        hit_any   = 1'b0;
        hit_ppn   = '0;
        hit_flags = '0;
        rf_match  = 1'b0;
        rf_idx    = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        sf_match  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && vpn_q[i] == bus.req_vpn) begin
                hit_any   = 1'b1;
                hit_ppn   = ppn_q[i];
                hit_flags = flags_q[i];
            end
            if (valid[i] && vpn_q[i] == bus.refill_vpn) begin
                rf_match = 1'b1;
                rf_idx   = IW'(i);
            end
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
            sf_match[i] = valid[i] && vpn_q[i] == bus.sfence_vpn;
        end
        victim = rf_match ? rf_idx : free_any ? free_idx : rr_ptr;
    end
    assign bus.refill_ready = !bus.sfence_valid;
    assign accept           = bus.refill_valid && !bus.sfence_valid;
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            valid        <= '0;
            rr_ptr       <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_ppn_q   <= '0;
            resp_flags_q <= '0;
        end else begin
            if (bus.sfence_valid)
                valid <= bus.sfence_all ? '0 : valid & ~sf_match;
            else if (accept)
                valid[victim] <= 1'b1;
            // Power-of-two depth makes the increment wrap on its own.
            if (accept && !rf_match && !free_any)
                rr_ptr <= rr_ptr + 1'b1;
            resp_valid_q <= bus.req_valid;
            resp_hit_q   <= bus.req_valid && hit_any;
            resp_ppn_q   <= bus.req_valid ? hit_ppn : '0;
            resp_flags_q <= bus.req_valid ? hit_flags : '0;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            vpn_q[victim]   <= bus.refill_vpn;
            ppn_q[victim]   <= bus.refill_ppn;
            flags_q[victim] <= bus.refill_flags;
        end
    end
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_hit   = resp_hit_q;
    assign bus.resp_ppn   = resp_ppn_q;
    assign bus.resp_flags = resp_flags_q;
endmodule

// File: tb/tb_tlb_entry_array.sv
// tb_tlb_entry_array: directed stimulus with a response scoreboard for tlb_entry_array
module tb_tlb_entry_array;
    logic clk = 1'b0;
    logic rstnn = 1'b0;
    int   total = 0;
    int   passed = 0;
    logic [36:0] exp_q [$];
    tlb_entry_array_if #(.VPN_W(27), .PPN_W(20)) bus ();
    tlb_entry_array #(.ENTRIES(8), .VPN_W(27), .PPN_W(20)) dut (
        .clk   (clk),
        .rstnn (rstnn),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask
    task automatic clear();
        bus.req_valid    = 1'b0;
        bus.refill_valid = 1'b0;
        bus.sfence_valid = 1'b0;
        bus.sfence_all   = 1'b0;
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        clear();
    endtask
    task automatic look(input logic [26:0] vpn, input logic hit, input logic [19:0] ppn, input logic [15:0] flags);
        bus.req_valid = 1'b1;
        bus.req_vpn   = vpn;
        exp_q.push_back({hit, ppn, flags});
    endtask
    task automatic fill(input logic [26:0] vpn, input logic [19:0] ppn, input logic [15:0] flags);
        bus.refill_valid = 1'b1;
        bus.refill_vpn   = vpn;
        bus.refill_ppn   = ppn;
        bus.refill_flags = flags;
    endtask
    task automatic sfence(input logic all, input logic [26:0] vpn);
        bus.sfence_valid = 1'b1;
        bus.sfence_all   = all;
        bus.sfence_vpn   = vpn;
    endtask
    always @(negedge clk) begin
        if (rstnn && bus.resp_valid) begin
            if (exp_q.size() == 0) check("unexpected_resp", 64'(bus.resp_valid), 64'd0);
            else check("resp", 64'({bus.resp_hit, bus.resp_ppn, bus.resp_flags}), 64'(exp_q.pop_front()));
        end
    end
    initial begin
        clear();
        bus.req_vpn = '0; bus.refill_vpn = '0; bus.refill_ppn = '0; bus.refill_flags = '0; bus.sfence_vpn = '0;
        #1;
        check("rst_outputs", 64'({bus.resp_valid, bus.resp_hit, bus.resp_ppn, bus.resp_flags}), 64'd0);
        check("rst_ready", 64'(bus.refill_ready), 64'd1);
        #21 rstnn = 1'b1;
        tick();
        look(27'h123, 1'b0, 20'h0, 16'h0); tick();
        fill(27'h123, 20'h8ABCD, 16'hA5C3);
        look(27'h123, 1'b0, 20'h0, 16'h0);
        #1 check("ready_idle", 64'(bus.refill_ready), 64'd1);
        tick();
        look(27'h123, 1'b1, 20'h8ABCD, 16'hA5C3); tick();
        for (int i = 1; i < 8; i++) begin
            fill(27'h200 + 27'(i), 20'h10000 + 20'(i), 16'h1000 | 16'(i));
            tick();
        end
        fill(27'h300, 20'h30000, 16'h3000); tick();
        look(27'h123, 1'b0, 20'h0, 16'h0); tick();
        look(27'h300, 1'b1, 20'h30000, 16'h3000); tick();
        look(27'h207, 1'b1, 20'h10007, 16'h1007); tick();
        fill(27'h301, 20'h30001, 16'h3001); tick();
        look(27'h201, 1'b0, 20'h0, 16'h0); tick();
        look(27'h301, 1'b1, 20'h30001, 16'h3001); tick();
        fill(27'h202, 20'h7777, 16'hFFFF); tick();
        look(27'h202, 1'b1, 20'h7777, 16'hFFFF); tick();
        fill(27'h302, 20'h30002, 16'h3002); tick();
        look(27'h202, 1'b0, 20'h0, 16'h0); tick();
        look(27'h203, 1'b1, 20'h10003, 16'h1003); tick();
        sfence(1'b1, 27'h0);
        look(27'h300, 1'b1, 20'h30000, 16'h3000); tick();
        look(27'h300, 1'b0, 20'h0, 16'h0); tick();
        fill(27'h400, 20'h40000, 16'h4000); tick();
        fill(27'h401, 20'h40001, 16'h4001); tick();
        fill(27'h402, 20'h40002, 16'h4002); tick();
        sfence(1'b0, 27'h401); tick();
        look(27'h400, 1'b1, 20'h40000, 16'h4000); tick();
        look(27'h401, 1'b0, 20'h0, 16'h0); tick();
        look(27'h402, 1'b1, 20'h40002, 16'h4002); tick();
        for (int i = 3; i < 9; i++) begin
            fill(27'h400 + 27'(i), 20'h40000 + 20'(i), 16'h4000 | 16'(i));
            tick();
        end
        fill(27'h409, 20'h40009, 16'h4009); tick();
        look(27'h404, 1'b0, 20'h0, 16'h0); tick();
        look(27'h403, 1'b1, 20'h40003, 16'h4003); tick();
        look(27'h409, 1'b1, 20'h40009, 16'h4009); tick();
        sfence(1'b1, 27'h0); tick();
        look(27'h400, 1'b0, 20'h0, 16'h0); tick();
        look(27'h402, 1'b0, 20'h0, 16'h0); tick();
        look(27'h403, 1'b0, 20'h0, 16'h0); tick();
        fill(27'h500, 20'h50000, 16'h5A5A);
        sfence(1'b1, 27'h0);
        #1 check("ready_sfence", 64'(bus.refill_ready), 64'd0);
        tick();
        fill(27'h500, 20'h50000, 16'h5A5A);
        #1 check("ready_held", 64'(bus.refill_ready), 64'd1);
        tick();
        look(27'h500, 1'b1, 20'h50000, 16'h5A5A); tick();
        fill(27'h501, 20'h50001, 16'h0001); tick();
        bus.req_valid = 1'b1;
        bus.req_vpn   = 27'h500;
        tick();
        check("pending_valid", 64'(bus.resp_valid), 64'd1);
        #1 rstnn = 1'b0;
        #1 check("async_rst", 64'({bus.resp_valid, bus.resp_hit, bus.resp_ppn, bus.resp_flags}), 64'd0);
        #4 rstnn = 1'b1;
        tick();
        check("post_rst_idle", 64'(bus.resp_valid), 64'd0);
        look(27'h500, 1'b0, 20'h0, 16'h0); tick();
        look(27'h501, 1'b0, 20'h0, 16'h0); tick();
        repeat (3) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
